// File: rtl/seven_segment_reader.sv
// Seven-segment readback monitor: samples the multiplexed anode/segment drive, debounces each
// digit dwell and reconstructs the displayed 4-digit decimal value frame by frame.
module seven_segment_reader #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2097152
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_sel,
  input  logic [6:0]  led_out,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SettleMax  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {StCollect, StPublish} state_e;

  state_e st_q, st_d;

  logic [10:0]      samp_q;
  logic             samp_chg;
  logic [SW-1:0]    stab_q, stab_d;
  logic             held_q, held_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic [3:0]       coll_q, coll_d;
  logic [3:0]       slot_err_q, slot_err_d;
  logic [3:0]       slot_blank_q, slot_blank_d;
  logic [3:0][3:0]  slot_q, slot_d;

  logic [15:0]      digits_q, digits_d;
  logic [13:0]      value_q, value_d;
  logic [3:0]       blank_q, blank_d;
  logic             fv_q, fv_d;
  logic             chg_q, chg_d;
  logic             serr_q, serr_d;

  logic [3:0]       samp_an;
  logic [6:0]       samp_seg;
  logic [1:0]       cap_idx;
  logic             an_valid;
  logic             cap_en;
  logic [3:0]       dec_digit;
  logic             dec_blank;
  logic             dec_err;
  logic [13:0]      value_calc;

  assign samp_an  = samp_q[10:7];
  assign samp_seg = samp_q[6:0];
  assign samp_chg = ({anode_sel, led_out} != samp_q);

  // Stability counter restarts at 1 whenever the sample changes; held_q marks that the
  // current dwell has already produced its single capture.
  always_comb begin
    stab_d = stab_q;
    held_d = held_q;
    if (samp_chg) begin
      stab_d = SW'(1);
      held_d = 1'b0;
    end else begin
      if (stab_q != SettleMax) stab_d = stab_q + SW'(1);
      held_d = (stab_q == SettleMax);
    end
  end

  // Only a single low anode bit selects a digit; everything else is ignored.
  always_comb begin
    cap_idx  = 2'd0;
    an_valid = 1'b1;
    case (samp_an)
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  assign cap_en = (stab_q == SettleMax) && !held_q && an_valid;

  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (samp_seg)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_err   = 1'b1;
    endcase
  end

  assign value_calc = 14'(slot_q[3]) * 14'd1000 + 14'(slot_q[2]) * 14'd100
                    + 14'(slot_q[1]) * 14'd10 + 14'(slot_q[0]);

  always_comb begin
    st_d         = st_q;
    coll_d       = coll_q;
    slot_err_d   = slot_err_q;
    slot_blank_d = slot_blank_q;
    slot_d       = slot_q;
    digits_d     = digits_q;
    value_d      = value_q;
    blank_d      = blank_q;
    fv_d         = 1'b0;
    chg_d        = 1'b0;
    serr_d       = 1'b0;

    case (st_q)
      StCollect: begin
        if (coll_q == 4'hf) begin
          st_d = StPublish;
          fv_d = 1'b1;
          if (|slot_err_q) begin
            serr_d = 1'b1;
          end else begin
            digits_d = slot_q;
            value_d  = value_calc;
            blank_d  = slot_blank_q;
            chg_d    = (value_calc != value_q);
          end
        end
      end
      StPublish: begin
        st_d       = StCollect;
        coll_d     = 4'h0;
        slot_err_d = 4'h0;
      end
      default: st_d = StCollect;
    endcase

    // Applied after the PUBLISH clear so a coincident capture lands in the new frame.
    if (cap_en) begin
      coll_d[cap_idx]       = 1'b1;
      slot_d[cap_idx]       = dec_digit;
      slot_err_d[cap_idx]   = dec_err;
      slot_blank_d[cap_idx] = dec_blank;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (fv_q) begin
      tcnt_d = '0;
    end else if (tcnt_q != TimeoutMax) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q       <= '1;
      stab_q       <= '0;
      held_q       <= 1'b0;
      tcnt_q       <= '0;
      st_q         <= StCollect;
      coll_q       <= '0;
      slot_err_q   <= '0;
      slot_blank_q <= '0;
      slot_q       <= '0;
      digits_q     <= '0;
      value_q      <= '0;
      blank_q      <= '0;
      fv_q         <= 1'b0;
      chg_q        <= 1'b0;
      serr_q       <= 1'b0;
    end else begin
      samp_q       <= {anode_sel, led_out};
      stab_q       <= stab_d;
      held_q       <= held_d;
      tcnt_q       <= tcnt_d;
      st_q         <= st_d;
      coll_q       <= coll_d;
      slot_err_q   <= slot_err_d;
      slot_blank_q <= slot_blank_d;
      slot_q       <= slot_d;
      digits_q     <= digits_d;
      value_q      <= value_d;
      blank_q      <= blank_d;
      fv_q         <= fv_d;
      chg_q        <= chg_d;
      serr_q       <= serr_d;
    end
  end

  assign digits      = digits_q;
  assign value       = value_q;
  assign blank_mask  = blank_q;
  assign frame_valid = fv_q;
  assign changed     = chg_q;
  assign seg_err     = serr_q;
  assign stale       = (tcnt_q == TimeoutMax);

endmodule
